// File: rtl/config_frame_sequencer.sv
// config_frame_sequencer
//
// Configuration-side transmitter for the frame data bus. It accepts one
// configuration word per fabric row over a valid/ready stream and broadcasts
// it on the shared frame data bus with a row select code (1..NumberOfRows).
// After the last row it fires a single-cycle frame strobe that carries the
// captured frame address.
//
// Ports
//   CLK            clock, all state changes on posedge
//   RST            synchronous active-high reset
//   Start          begin a frame (sampled only in IDLE)
//   FrameAddr_I    frame address, captured with the accepted Start
//   WordData_I     configuration word for the next row
//   WordValid_I    WordData_I valid
//   WordReady_O    sequencer accepts a word this cycle
//   FrameData_O    frame data bus to the row registers
//   RowSelect_O    row select code, 0 = no row selected
//   FrameStrobe_O  one-cycle strobe committing the frame
//   FrameAddr_O    frame address, valid while FrameStrobe_O = 1
//   Busy_O         high in any state other than IDLE
//   Done_O         one-cycle pulse after the strobe
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for Start; no word accepted
// LOAD   | accepting one word per handshake, rows 1..NumberOfRows
// FLUSH  | last row code is on the bus; no word accepted
// STROBE | FrameStrobe_O high with the captured frame address

module config_frame_sequencer #(
  parameter int FrameBitsPerRow  = 32,
  parameter int RowSelectWidth   = 5,
  parameter int NumberOfRows     = 15,
  parameter int FrameSelectWidth = 5
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        Start,
  input  logic [FrameSelectWidth-1:0] FrameAddr_I,
  input  logic [FrameBitsPerRow-1:0]  WordData_I,
  input  logic                        WordValid_I,
  output logic                        WordReady_O,
  output logic [FrameBitsPerRow-1:0]  FrameData_O,
  output logic [RowSelectWidth-1:0]   RowSelect_O,
  output logic                        FrameStrobe_O,
  output logic [FrameSelectWidth-1:0] FrameAddr_O,
  output logic                        Busy_O,
  output logic                        Done_O
);

  if (NumberOfRows > (2 ** RowSelectWidth) - 1) begin : g_param_check
    $error("NumberOfRows does not fit in the row select code");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_STROBE
  } state_t;

  localparam logic [RowSelectWidth-1:0] FIRST_ROW = RowSelectWidth'(1);
  localparam logic [RowSelectWidth-1:0] LAST_ROW  = RowSelectWidth'(NumberOfRows);

  state_t                        state_q;
  state_t                        state_d;
  logic [RowSelectWidth-1:0]     row_cnt_q;
  logic [FrameBitsPerRow-1:0]    frame_data_q;
  logic [RowSelectWidth-1:0]     row_sel_q;
  logic [FrameSelectWidth-1:0]   frame_addr_q;
  logic                          done_q;
  logic                          word_ready;
  logic                          frame_strobe;
  logic                          handshake;

  assign handshake = WordValid_I & word_ready;

  always_comb begin
    state_d      = state_q;
    word_ready   = 1'b0;
    frame_strobe = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Ready depends on the state only, never on WordValid_I.
        word_ready = 1'b1;
        if (WordValid_I && (row_cnt_q == LAST_ROW)) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        frame_strobe = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      row_cnt_q    <= FIRST_ROW;
      frame_data_q <= '0;
      row_sel_q    <= '0;
      frame_addr_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_STROBE);

      // Row code is live for exactly one cycle per accepted word; the data
      // bus keeps its last value so the row registers see a stable bus.
      if (handshake) begin
        frame_data_q <= WordData_I;
        row_sel_q    <= row_cnt_q;
        // Saturate at the last row; the counter is reloaded on Start.
        if (row_cnt_q != LAST_ROW) row_cnt_q <= row_cnt_q + FIRST_ROW;
      end else begin
        row_sel_q <= '0;
      end

      if ((state_q == ST_IDLE) && Start) begin
        frame_addr_q <= FrameAddr_I;
        row_cnt_q    <= FIRST_ROW;
      end
    end
  end

  assign WordReady_O   = word_ready;
  assign FrameData_O   = frame_data_q;
  assign RowSelect_O   = row_sel_q;
  assign FrameStrobe_O = frame_strobe;
  // Address is only presented with the strobe so the bus stays quiet otherwise.
  assign FrameAddr_O   = frame_strobe ? frame_addr_q : '0;
  assign Busy_O        = (state_q != ST_IDLE);
  assign Done_O        = done_q;

endmodule

// File: tb/tb_config_frame_sequencer.sv
module tb_config_frame_sequencer;

  localparam int FB = 32;
  localparam int RW = 5;
  localparam int NR = 15;
  localparam int FW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Start;
  logic [FW-1:0] FrameAddr_I;
  logic [FB-1:0] WordData_I;
  logic          WordValid_I;
  logic          WordReady_O;
  logic [FB-1:0] FrameData_O;
  logic [RW-1:0] RowSelect_O;
  logic          FrameStrobe_O;
  logic [FW-1:0] FrameAddr_O;
  logic          Busy_O;
  logic          Done_O;

  always #5 CLK = ~CLK;

  config_frame_sequencer #(
    .FrameBitsPerRow (FB),
    .RowSelectWidth  (RW),
    .NumberOfRows    (NR),
    .FrameSelectWidth(FW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Start        (Start),
    .FrameAddr_I  (FrameAddr_I),
    .WordData_I   (WordData_I),
    .WordValid_I  (WordValid_I),
    .WordReady_O  (WordReady_O),
    .FrameData_O  (FrameData_O),
    .RowSelect_O  (RowSelect_O),
    .FrameStrobe_O(FrameStrobe_O),
    .FrameAddr_O  (FrameAddr_O),
    .Busy_O       (Busy_O),
    .Done_O       (Done_O)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [RW-1:0] row;
    logic [FB-1:0] data;
  } beat_t;
  beat_t sb[$];

  typedef struct {
    logic          st;
    logic [FW-1:0] fa;
    logic          v;
    logic [FB-1:0] wd;
    logic [RW-1:0] exp_sel;
    logic          exp_strobe;
    logic          exp_done;
  } vec_t;
  vec_t tbl[$];

  // Bench-side model: 0 idle, 1 load, 2 flush, 3 strobe
  int            m_phase = 0;
  int            m_row   = 1;
  logic [FW-1:0] m_addr  = '0;
  logic          m_done  = 1'b0;
  logic [FB-1:0] last_data = '0;
  logic [FB-1:0] words  [1:NR];
  logic [FB-1:0] rx_reg [1:NR];
  int            rx_cnt [1:NR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic rst, input logic st, input logic [FW-1:0] fa,
                      input logic v, input logic [FB-1:0] wd);
    beat_t b;
    int    idx;
    RST = rst; Start = st; FrameAddr_I = fa; WordValid_I = v; WordData_I = wd;
    if (rst) begin
      m_phase = 0; m_row = 1; m_done = 1'b0; last_data = '0;
      sb.delete();
    end else begin
      m_done = (m_phase == 3);
      case (m_phase)
        0: if (st) begin
          m_phase = 1; m_row = 1; m_addr = fa;
          for (int i = 1; i <= NR; i++) rx_cnt[i] = 0;
        end
        1: if (v) begin
          b.row = RW'(m_row); b.data = wd;
          sb.push_back(b);
          words[m_row] = wd;
          if (m_row == NR) m_phase = 2;
          m_row++;
        end
        2: m_phase = 3;
        default: m_phase = 0;
      endcase
    end
    @(posedge CLK);
    #1;
    idx = int'(RowSelect_O);
    if (idx >= 1 && idx <= NR) begin
      rx_reg[idx] = FrameData_O;
      rx_cnt[idx]++;
    end
    if (sb.size() > 0) begin
      b = sb.pop_front();
      chk("row_sel", 32'(RowSelect_O), 32'(b.row));
      chk("frame_data", FrameData_O, b.data);
      last_data = b.data;
    end else begin
      chk("row_idle", 32'(RowSelect_O), 32'd0);
      chk("data_hold", FrameData_O, last_data);
    end
    chk("strobe", 32'(FrameStrobe_O), 32'(m_phase == 3));
    if (m_phase == 3) begin
      chk("frame_addr", 32'(FrameAddr_O), 32'(m_addr));
      for (int r = 1; r <= NR; r++) begin
        chk("rx_word", rx_reg[r], words[r]);
        chk("rx_count", 32'(rx_cnt[r]), 32'd1);
      end
    end
    chk("done", 32'(Done_O), 32'(m_done));
    chk("busy", 32'(Busy_O), 32'(m_phase != 0));
    chk("ready", 32'(WordReady_O), 32'(m_phase == 1));
  endtask

  initial begin
    vec_t e;
    // Backpressure frame: valid 1,0,0 per row, a Start pulse with address 3
    // during a gap, and valid held high through the FLUSH cycle.
    e = '{1'b1, 5'd9, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0};
    tbl.push_back(e);
    for (int r = 1; r <= NR; r++) begin
      e = '{1'b0, 5'd0, 1'b1, 32'hA000_0000 | 32'(r), RW'(r), 1'b0, 1'b0};
      tbl.push_back(e);
      if (r < NR) begin
        e = '{(r == 7), (r == 7) ? 5'd3 : 5'd0, 1'b0, 32'hDEAD_0000 | 32'(r), 5'd0, 1'b0, 1'b0};
        tbl.push_back(e);
        e = '{1'b0, 5'd0, 1'b0, 32'hBEEF_0000 | 32'(r), 5'd0, 1'b0, 1'b0};
        tbl.push_back(e);
      end
    end
    e = '{1'b0, 5'd0, 1'b1, 32'hBAD0_BAD0, 5'd0, 1'b1, 1'b0};
    tbl.push_back(e);
    e = '{1'b0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1};
    tbl.push_back(e);

    for (int r = 1; r <= NR; r++) begin
      rx_reg[r] = '0; rx_cnt[r] = 0; words[r] = '0;
    end

    // Reset state
    tick(1'b1, 1'b0, '0, 1'b0, '0);
    tick(1'b1, 1'b0, '0, 1'b0, '0);
    chk("reset_addr", 32'(FrameAddr_O), 32'd0);
    tick(1'b0, 1'b0, '0, 1'b0, '0);

    // Streaming frame, address 9, valid held high
    tick(1'b0, 1'b1, 5'd9, 1'b0, '0);
    for (int r = 1; r <= NR; r++) tick(1'b0, 1'b0, '0, 1'b1, 32'h1000_0000 + 32'(r));
    tick(1'b0, 1'b0, '0, 1'b0, '0);   // strobe visible
    tick(1'b0, 1'b0, '0, 1'b0, '0);   // Done visible
    chk("done_cycle", 32'(Done_O), 32'd1);

    // Back-to-back: Start driven in the Done cycle
    tick(1'b0, 1'b1, 5'd21, 1'b0, '0);
    chk("b2b_accept", 32'(Busy_O), 32'd1);
    for (int r = 1; r <= NR; r++) tick(1'b0, 1'b0, '0, 1'b1, 32'h2000_0000 + 32'(r * 3));
    tick(1'b0, 1'b0, '0, 1'b0, '0);
    chk("b2b_strobe_addr", 32'(FrameAddr_O), 32'd21);
    tick(1'b0, 1'b0, '0, 1'b0, '0);
    tick(1'b0, 1'b0, '0, 1'b0, '0);

    // Table-driven backpressure frame
    for (int i = 0; i < tbl.size(); i++) begin
      tick(1'b0, tbl[i].st, tbl[i].fa, tbl[i].v, tbl[i].wd);
      chk("tbl_sel", 32'(RowSelect_O), 32'(tbl[i].exp_sel));
      chk("tbl_strobe", 32'(FrameStrobe_O), 32'(tbl[i].exp_strobe));
      chk("tbl_done", 32'(Done_O), 32'(tbl[i].exp_done));
      if (tbl[i].exp_strobe) chk("tbl_addr", 32'(FrameAddr_O), 32'd9);
    end
    tick(1'b0, 1'b0, '0, 1'b0, '0);

    // Reset mid-frame with row 7 pending
    tick(1'b0, 1'b1, 5'd12, 1'b0, '0);
    for (int r = 1; r <= 6; r++) tick(1'b0, 1'b0, '0, 1'b1, 32'h3000_0000 + 32'(r));
    tick(1'b1, 1'b1, 5'd4, 1'b1, 32'h3000_0007);
    chk("rst_sel", 32'(RowSelect_O), 32'd0);
    chk("rst_data", FrameData_O, 32'd0);
    tick(1'b1, 1'b0, '0, 1'b0, '0);
    chk("rst_busy", 32'(Busy_O), 32'd0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, '0, 1'b0, '0);

    // Restart after reset begins at row 1
    tick(1'b0, 1'b1, 5'd17, 1'b0, '0);
    tick(1'b0, 1'b0, '0, 1'b1, 32'h4000_0001);
    chk("restart_row1", 32'(RowSelect_O), 32'd1);
    for (int r = 2; r <= NR; r++) tick(1'b0, 1'b0, '0, 1'b1, 32'h4000_0000 + 32'(r));
    tick(1'b0, 1'b0, '0, 1'b0, '0);
    chk("restart_strobe_addr", 32'(FrameAddr_O), 32'd17);
    tick(1'b0, 1'b0, '0, 1'b0, '0);
    tick(1'b0, 1'b0, '0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
